// File: rtl/dmem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : dmem_responder_if                                            |
// | Memory-stage data bus between the pipeline (master) and the data-memory  |
// | responder (slave): request, store data, load data and status.            |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
interface dmem_responder_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MemAckM;
  logic        MemErrM;
  logic [7:0]  ErrCount;

  // Pipeline side: issues accesses, observes data and status
  modport master (
    output MemReqM, MemWriteM, ALUOutM, WriteDataM,
    input  ReadDataM, MemStallM, MemAckM, MemErrM, ErrCount
  );

  // Responder side
  modport slave (
    input  MemReqM, MemWriteM, ALUOutM, WriteDataM,
    output ReadDataM, MemStallM, MemAckM, MemErrM, ErrCount
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : dmem_responder                                               |
// | Word-addressed data memory on the M-stage bus. Accepts one load/store,   |
// | stalls the pipeline for LATENCY cycles, then acks with data and an error |
// | flag for misaligned/out-of-range addresses; errors are counted.          |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int         C_WORDS    = 2 ** DEPTH_LOG2;
  localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           data_q, data_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            errcnt_q, errcnt_d;

  logic [31:0]           mem_q [0:C_WORDS-1];

  logic                  w_req_err;
  logic                  w_enter_done;
  logic                  w_mem_we;

  // Any low address bit set (misaligned) or any bit above the index range
  // (word >= C_WORDS) makes the access an error.
  assign w_req_err = (|bus.ALUOutM[1:0]) | (|bus.ALUOutM[31:DEPTH_LOG2+2]);

  // Next-state: capture the request in IDLE, count down in BUSY, ack in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    write_d = write_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.MemReqM) begin
          idx_d   = bus.ALUOutM[DEPTH_LOG2+1:2];
          data_d  = bus.WriteDataM;
          write_d = bus.MemWriteM;
          err_d   = w_req_err;
          cnt_d   = C_CNT_INIT;
          state_d = (LATENCY == 1) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The commit edge is the one entering DONE. The _d copies hold the live
  // request for a single-cycle access and the latched one otherwise.
  assign w_enter_done = (state_d == S_DONE) && (state_q != S_DONE);
  assign w_mem_we     = w_enter_done && write_d && !err_d;

  // Load data and error counter updates on the commit edge
  always_comb begin
    rdata_d  = rdata_q;
    errcnt_d = errcnt_q;
    if (w_enter_done) begin
      rdata_d = (write_d || err_d) ? 32'd0 : mem_q[idx_d];
      if (err_d && (errcnt_q != 8'hFF)) begin
        errcnt_d = errcnt_q + 8'd1;
      end
    end
  end

  // Control and status registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      data_q   <= 32'd0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      write_q  <= write_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Storage array: not cleared by reset; a store is dropped if reset hits
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      mem_q[idx_d] <= data_d;
    end
  end

  assign bus.MemStallM = !reset &&
                         (((state_q == S_IDLE) && bus.MemReqM) || (state_q == S_BUSY));
  assign bus.MemAckM   = (state_q == S_DONE);
  assign bus.MemErrM   = (state_q == S_DONE) && err_q;
  assign bus.ReadDataM = rdata_q;
  assign bus.ErrCount  = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_dmem_responder                                            |
// | Self-checking bench: LATENCY=2 responder checked against a word-array    |
// | model, plus a LATENCY=1 instance for single-cycle stall behaviour.       |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int DEPTH_LOG2 = 6;
  localparam int LATENCY    = 2;
  localparam int C_WORDS    = 2 ** DEPTH_LOG2;
  localparam int C_TIMEOUT  = 40;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  dmem_responder_if u_if ();
  dmem_responder_if u_if1 ();

  dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem [C_WORDS];
  int          model_errcnt = 0;

  // Reference: error if misaligned or beyond the last word
  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * C_WORDS));
  endfunction

  // Reference: apply one access to the model, give expected ReadDataM/MemErrM
  task automatic model_apply(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] exp_rd, output logic exp_err);
    int w;
    exp_err = model_err(a);
    w = int'(a >> 2) % C_WORDS;
    if (wr && !exp_err) model_mem[w] = d;
    exp_rd = (wr || exp_err) ? 32'd0 : model_mem[w];
    if (exp_err && model_errcnt < 255) model_errcnt++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = (32'($urandom_range(0, C_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
      1:       a = $urandom | 32'h0000_0100;
      default: a = 32'($urandom_range(0, C_WORDS - 1)) << 2;
    endcase
    return a;
  endfunction

  // Driver: issue one access at a negedge, scramble inputs while busy and in
  // DONE (must be ignored), return at the negedge after the DUT is idle again.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic keep_req, output logic [31:0] rdata, output logic err,
                        output int stall_cyc, output logic acked);
    u_if.MemReqM    = 1'b1;
    u_if.MemWriteM  = wr;
    u_if.ALUOutM    = addr;
    u_if.WriteDataM = data;
    #1;
    stall_cyc = u_if.MemStallM ? 1 : 0;
    acked = 1'b0;
    rdata = 32'd0;
    err   = 1'b0;
    @(posedge clk);
    for (int i = 0; i < C_TIMEOUT; i++) begin
      @(negedge clk);
      if (u_if.MemAckM) begin
        acked = 1'b1;
        rdata = u_if.ReadDataM;
        err   = u_if.MemErrM;
        break;
      end
      if (u_if.MemStallM) stall_cyc++;
      u_if.MemReqM    = 1'b1;
      u_if.MemWriteM  = 1'($urandom);
      u_if.ALUOutM    = $urandom;
      u_if.WriteDataM = $urandom;
    end
    if (acked) begin
      u_if.MemReqM    = 1'b1;
      u_if.MemWriteM  = 1'b1;
      u_if.ALUOutM    = $urandom & 32'h0000_00FC;
      u_if.WriteDataM = $urandom;
      @(negedge clk);
    end
    u_if.MemReqM   = keep_req;
    u_if.MemWriteM = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_if.MemReqM = 1'b0;  u_if.MemWriteM = 1'b0;  u_if.ALUOutM = 32'd0;  u_if.WriteDataM = 32'd0;
    u_if1.MemReqM = 1'b0; u_if1.MemWriteM = 1'b0; u_if1.ALUOutM = 32'd0; u_if1.WriteDataM = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    u_if.MemReqM = 1'b1;
    #1;
    checks++;
    if (u_if.MemStallM !== 1'b0) begin
      failures++; $display("FAIL reset_stall_gate: got %b expected 0", u_if.MemStallM);
    end
    u_if.MemReqM = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (u_if.ReadDataM !== 32'd0) begin
      failures++; $display("FAIL reset_rdata: got %h expected 0", u_if.ReadDataM);
    end
    checks++;
    if (u_if.MemStallM !== 1'b0) begin
      failures++; $display("FAIL reset_stall: got %b expected 0", u_if.MemStallM);
    end
    checks++;
    if (u_if.MemAckM !== 1'b0 || u_if.MemErrM !== 1'b0) begin
      failures++; $display("FAIL reset_ack_err: got ack=%b err=%b expected 0 0", u_if.MemAckM, u_if.MemErrM);
    end
    checks++;
    if (u_if.ErrCount !== 8'd0) begin
      failures++; $display("FAIL reset_errcount: got %0d expected 0", u_if.ErrCount);
    end
  endtask

  task automatic test_init();
    logic [31:0] rd, erd; logic e, ee, ack; int st; int missed = 0;
    for (int w = 0; w < C_WORDS; w++) begin
      logic [31:0] d = $urandom;
      model_apply(1'b1, 32'(w) << 2, d, erd, ee);
      access(1'b1, 32'(w) << 2, d, 1'b0, rd, e, st, ack);
      if (!ack) missed++;
    end
    checks++;
    if (missed !== 0) begin
      failures++; $display("FAIL init_acks: got %0d missing acks expected 0", missed);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic e, ee, ack; int st;
    model_apply(1'b1, 32'h10, 32'hDEADBEEF, erd, ee);
    access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, e, st, ack);
    checks++;
    if (!ack || st !== LATENCY || e !== 1'b0 || rd !== 32'd0) begin
      failures++;
      $display("FAIL store_basic: got ack=%b stall=%0d err=%b rd=%h expected 1 %0d 0 0", ack, st, e, rd, LATENCY);
    end
    model_apply(1'b0, 32'h10, 32'd0, erd, ee);
    access(1'b0, 32'h10, 32'd0, 1'b0, rd, e, st, ack);
    checks++;
    if (!ack || st !== LATENCY || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_basic: got ack=%b stall=%0d err=%b rd=%h expected 1 %0d 0 deadbeef", ack, st, e, rd, LATENCY);
    end
    checks++;
    if (u_if.ReadDataM !== 32'hDEADBEEF) begin
      failures++; $display("FAIL load_hold: got %h expected deadbeef", u_if.ReadDataM);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, erd; logic e, ee, ack; int st;
    model_apply(1'b0, 32'h13, 32'd0, erd, ee);
    access(1'b0, 32'h13, 32'd0, 1'b0, rd, e, st, ack);
    checks++;
    if (!ack || e !== 1'b1 || rd !== 32'd0 || st !== LATENCY) begin
      failures++; $display("FAIL misaligned: got ack=%b err=%b rd=%h stall=%0d expected 1 1 0 %0d", ack, e, rd, st, LATENCY);
    end
    checks++;
    if (u_if.ErrCount !== 8'd1) begin
      failures++; $display("FAIL misaligned_count: got %0d expected 1", u_if.ErrCount);
    end
    model_apply(1'b0, 32'h10, 32'd0, erd, ee);
    access(1'b0, 32'h10, 32'd0, 1'b0, rd, e, st, ack);
    checks++;
    if (rd !== erd) begin
      failures++; $display("FAIL misaligned_nochange: got %h expected %h", rd, erd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, erd; logic e, ee, ack; int st;
    model_apply(1'b1, 32'h100, 32'hA5A5_5A5A, erd, ee);
    access(1'b1, 32'h100, 32'hA5A5_5A5A, 1'b0, rd, e, st, ack);
    checks++;
    if (!ack || e !== 1'b1) begin
      failures++; $display("FAIL oor_store: got ack=%b err=%b expected 1 1", ack, e);
    end
    checks++;
    if (u_if.ErrCount !== 8'(model_errcnt)) begin
      failures++; $display("FAIL oor_count: got %0d expected %0d", u_if.ErrCount, model_errcnt);
    end
    model_apply(1'b0, 32'h0, 32'd0, erd, ee);
    access(1'b0, 32'h0, 32'd0, 1'b0, rd, e, st, ack);
    checks++;
    if (rd !== erd || e !== 1'b0) begin
      failures++; $display("FAIL oor_nowrite: got rd=%h err=%b expected %h 0", rd, e, erd);
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd, erd; logic e, ee, ack; int st;
    u_if.MemReqM = 1'b1; u_if.MemWriteM = 1'b1; u_if.ALUOutM = 32'h20; u_if.WriteDataM = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    u_if.MemReqM = 1'b0;
    checks++;
    if (u_if.MemStallM !== 1'b1) begin
      failures++; $display("FAIL rstbusy_inbusy: got stall=%b expected 1", u_if.MemStallM);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_errcnt = 0;
    #1;
    checks++;
    if (u_if.MemAckM !== 1'b0 || u_if.MemStallM !== 1'b0 || u_if.ErrCount !== 8'd0) begin
      failures++;
      $display("FAIL rstbusy_idle: got ack=%b stall=%b errcnt=%0d expected 0 0 0", u_if.MemAckM, u_if.MemStallM, u_if.ErrCount);
    end
    @(negedge clk);
    checks++;
    if (u_if.MemAckM !== 1'b0) begin
      failures++; $display("FAIL rstbusy_noack: got %b expected 0", u_if.MemAckM);
    end
    model_apply(1'b0, 32'h20, 32'd0, erd, ee);
    access(1'b0, 32'h20, 32'd0, 1'b0, rd, e, st, ack);
    checks++;
    if (!ack || rd !== erd) begin
      failures++; $display("FAIL rstbusy_nocommit: got ack=%b rd=%h expected 1 %h", ack, rd, erd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd, d; logic e, ee, ack; int st; int t0;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      t0 = cyc;
      model_apply(1'b1, 32'h4, d, erd, ee);
      access(1'b1, 32'h4, d, 1'b1, rd, e, st, ack);
      checks++;
      if (cyc - t0 !== LATENCY + 1) begin
        failures++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", cyc - t0, LATENCY + 1);
      end
      model_apply(1'b0, 32'h4, 32'd0, erd, ee);
      access(1'b0, 32'h4, 32'd0, 1'b1, rd, e, st, ack);
      checks++;
      if (!ack || rd !== d || rd !== erd) begin
        failures++; $display("FAIL b2b_load: got %h expected %h", rd, d);
      end
    end
    u_if.MemReqM = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic e, ee, ack, wr; int st;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      a  = rand_addr();
      d  = $urandom;
      model_apply(wr, a, d, erd, ee);
      access(wr, a, d, 1'b0, rd, e, st, ack);
      checks++;
      if (!ack || rd !== erd || e !== ee || st !== LATENCY) begin
        failures++;
        $display("FAIL random_access: wr=%b a=%h got ack=%b rd=%h err=%b stall=%0d expected 1 %h %b %0d",
                 wr, a, ack, rd, e, st, erd, ee, LATENCY);
      end
      checks++;
      if (u_if.ErrCount !== 8'(model_errcnt)) begin
        failures++; $display("FAIL random_errcount: got %0d expected %0d", u_if.ErrCount, model_errcnt);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] rd, erd, a; logic e, ee, ack; int st;
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, C_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
      model_apply(1'b0, a, 32'd0, erd, ee);
      access(1'b0, a, 32'd0, 1'b0, rd, e, st, ack);
      checks++;
      if (u_if.ErrCount !== 8'(model_errcnt) || e !== 1'b1) begin
        failures++; $display("FAIL sat_count: got cnt=%0d err=%b expected %0d 1", u_if.ErrCount, e, model_errcnt);
      end
    end
    checks++;
    if (u_if.ErrCount !== 8'd255) begin
      failures++; $display("FAIL sat_final: got %0d expected 255", u_if.ErrCount);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = (i == 5) ? 32'h0000_0021 : 32'($urandom_range(0, C_WORDS - 1)) << 2;
      d = $urandom;
      @(negedge clk);
      u_if1.MemReqM = 1'b1; u_if1.MemWriteM = 1'b1; u_if1.ALUOutM = a; u_if1.WriteDataM = d;
      #1;
      checks++;
      if (u_if1.MemStallM !== 1'b1) begin
        failures++; $display("FAIL lat1_stall: got %b expected 1", u_if1.MemStallM);
      end
      @(negedge clk);
      u_if1.MemReqM = 1'b0;
      checks++;
      if (u_if1.MemAckM !== 1'b1 || u_if1.MemStallM !== 1'b0 || u_if1.MemErrM !== model_err(a)) begin
        failures++;
        $display("FAIL lat1_store_ack: got ack=%b stall=%b err=%b expected 1 0 %b", u_if1.MemAckM, u_if1.MemStallM, u_if1.MemErrM, model_err(a));
      end
      @(negedge clk);
      checks++;
      if (u_if1.MemAckM !== 1'b0) begin
        failures++; $display("FAIL lat1_ack_pulse: got %b expected 0", u_if1.MemAckM);
      end
      u_if1.MemReqM = 1'b1; u_if1.MemWriteM = 1'b0; u_if1.ALUOutM = a;
      @(negedge clk);
      u_if1.MemReqM = 1'b0;
      checks++;
      if (u_if1.MemAckM !== 1'b1 || u_if1.ReadDataM !== (model_err(a) ? 32'd0 : d)) begin
        failures++;
        $display("FAIL lat1_load: got ack=%b rd=%h expected 1 %h", u_if1.MemAckM, u_if1.ReadDataM, model_err(a) ? 32'd0 : d);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_reset_busy();
    test_back_to_back();
    test_random();
    test_saturation();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
